wb_regbank: RTL
===============

# wb_regbank

Parametrised Wishbone-classic register bank: `NREGS` 32-bit registers behind a single slave port, each configurable as read/write, read-only (hardware-fed) or write-1-to-clear (hardware-set status), with per-register reset values. It replaces hand-instantiated fixed register files in peripherals: the bus side gets a registered one-wait-state acknowledge and an error response for unmapped addresses; the hardware side gets flat register contents, write/read strobes and an interrupt line.

## Interface
- `NREGS`, 8: number of registers, 1..64; register k at byte address 4·k.
- `RESET_VALUES`, all zero: packed `NREGS`×32 vector; slice k is the reset value of register k.
- `MODES`, all RW: packed `NREGS`×2 vector; slice k is the mode of register k: 0 = RW, 1 = RO, 2 = W1C; 3 is reserved and behaves as RO.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, asynchronous, active-high.
- `stb_i` in 1: bus strobe (cycle valid).
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in 30 (`[31:2]`): word address.
- `sel_i` in 4: byte lane enables.
- `dat_i` in 32: write data.
- `dat_o` out 32: read data, valid while `ack_o`=1.
- `ack_o` out 1: transfer complete.
- `err_o` out 1: unmapped address.
- `hw_q_o` out `NREGS`·32: current contents of all registers.
- `hw_we_i` in `NREGS`: load strobe for RO registers.
- `hw_dat_i` in `NREGS`·32: load data for RO registers.
- `hw_set_i` in `NREGS`·32: bit-set requests for W1C registers.
- `wr_pulse_o` out `NREGS`: one-cycle strobe per register on a bus write.
- `rd_pulse_o` out `NREGS`: one-cycle strobe per register on a bus read.
- `irq_o` out 1: OR of all bits of all W1C registers.

## Operation
- Decode: index = `adr_i[31:2]`. An index ≥ `NREGS` (including any nonzero upper bits) is unmapped.
- FSM states: IDLE and RESP.
  - IDLE → RESP when `stb_i`=1. At that edge, `ack_o` (mapped) or `err_o` (unmapped) goes 1 and the access is performed.
  - RESP → IDLE unconditionally. `stb_i` is ignored in RESP, so every transfer is acknowledged exactly once.
- Reads:
  - `dat_o` captures the register value present before the edge.
  - Unmapped reads return 0.
  - The addressed `rd_pulse_o` bit is 1 for the RESP cycle.
- Writes: per byte lane with `sel_i[b]`=1:
  - RW: the byte is replaced by `dat_i`.
  - W1C: bits set in `dat_i` are cleared.
  - RO: no effect.
  - Non-selected lanes are unchanged.
  - The addressed `wr_pulse_o` bit is 1 for the RESP cycle regardless of mode or `sel_i`.
  - Unmapped writes change nothing.
- Hardware side:
  - RO register k loads `hw_dat_i` slice k on any edge where `hw_we_i[k]`=1.
  - W1C register k ORs in `hw_set_i` slice k every edge.
  - `hw_we_i` and `hw_set_i` are ignored for RW registers.
- Collisions:
  - The same W1C bit set by hardware and cleared by the bus in one edge ends set.
  - A bus write to an RO register during `hw_we_i` leaves the hardware value.
- `irq_o` is combinational from register contents.

## Timing
- Reset values:
  - `ack_o`, `err_o`, `dat_o`, `wr_pulse_o`, `rd_pulse_o` are 0.
  - FSM is in IDLE.
  - Register k = `RESET_VALUES` slice k.
  - `irq_o` = OR of the W1C reset values.
- Latency: `stb_i` sampled at edge n gives `ack_o`/`err_o` high in cycle n+1, for exactly one cycle.
- Write data is visible on `hw_q_o` in cycle n+1.
- Maximum throughput is one transfer per 2 cycles. A master holding `stb_i` continuously gets an ack every other cycle.
- `rst_i` asserted during RESP: `ack_o`/`err_o` drop immediately and no further response is issued.

## Structure
- Package `wb_regbank_pkg`: FSM state enum (IDLE, RESP) and mode constants MODE_RW=2'd0, MODE_RO=2'd1, MODE_W1C=2'd2.
- Sub-module `wb_regbank_cell`: one 32-bit register with mode, reset value, byte-lane write, W1C clear and hardware load/set logic. Generated `NREGS` times.
- The top level holds the decode, FSM, read mux and pulse/IRQ logic.

## Test plan
- Reset check, with `NREGS`=4, `RESET_VALUES`={DEADDEAD,03051996,12345678,0}, modes {RW,RO,W1C,RW} for regs 3..0: read each reg → values returned with `ack_o` in cycle n+1, `irq_o`=1 (reg 1 nonzero).
- Write reg 0 = 0xAABBCCDD with `sel_i`=4'b0101 after reset 0 → reads 0x00BB00DD; `wr_pulse_o[0]` high for one cycle.
- W1C: `hw_set_i` sets reg 1 to 0x0000_0011. Bus write 0x01 with `sel_i`=4'b0001 → 0x10, `irq_o`=1. Write 0x10 in the same edge as `hw_set_i` bit 4 → stays 0x10.
- RO: `hw_we_i[2]` loads 0xCAFEF00D. Bus write 0 to reg 2 → still 0xCAFEF00D; `wr_pulse_o[2]` pulses.
- Unmapped: read `adr_i`=4 and write `adr_i`=30'h2000_0000 → `err_o`=1, `ack_o`=0, `dat_o`=0, no register changes.
- Hold `stb_i`=1 for 6 cycles → exactly 3 acks on alternating cycles. Assert `rst_i` mid-RESP → `ack_o` drops asynchronously and the registers return to reset values.

Source files
------------

// File: rtl/wb_regbank_pkg.sv
// Shared types and constants for the Wishbone register bank.
package wb_regbank_pkg;

    // Bus handshake states: waiting for a strobe, or presenting the response.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Per-register access modes; the fourth encoding is treated as read-only.
    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;

    // Expands four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_regbank_cell.sv
// One 32-bit register of the bank. The mode parameter selects whether the
// bus writes it (RW), hardware loads it (RO), or hardware sets bits that
// the bus clears by writing ones (W1C).
module wb_regbank_cell
    import wb_regbank_pkg::*;
#(
    parameter logic [1:0]  MODE        = MODE_RW,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  sel,
    input  logic [31:0] wdat,
    input  logic        hw_we,
    input  logic [31:0] hw_dat,
    input  logic [31:0] hw_set,
    output logic [31:0] q
);

    logic [31:0] d;
    logic [31:0] mask;

    // Next value: hardware set wins over a bus clear, hardware load wins over
    // a bus write to a read-only register.
    always_comb begin
        mask = lane_mask(sel);
        d    = q;
        case (MODE)
            MODE_RW: begin
                if (wr_en) begin
                    d = (q & ~mask) | (wdat & mask);
                end
            end
            MODE_W1C: begin
                if (wr_en) begin
                    d = q & ~(wdat & mask);
                end
                d = d | hw_set;
            end
            default: begin
                if (hw_we) begin
                    d = hw_dat;
                end
            end
        endcase
    end

    // Register storage with per-register reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_regbank.sv
// Wishbone-classic register bank: address decode, one-wait-state handshake,
// read mux, per-register access strobes and the W1C interrupt summary.
module wb_regbank
    import wb_regbank_pkg::*;
#(
    parameter int                     NREGS        = 8,
    parameter logic [NREGS*32-1:0]    RESET_VALUES = '0,
    parameter logic [NREGS*2-1:0]     MODES        = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [31:2]           adr_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           dat_i,
    output logic [31:0]           dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [NREGS*32-1:0]   hw_q_o,
    input  logic [NREGS-1:0]      hw_we_i,
    input  logic [NREGS*32-1:0]   hw_dat_i,
    input  logic [NREGS*32-1:0]   hw_set_i,
    output logic [NREGS-1:0]      wr_pulse_o,
    output logic [NREGS-1:0]      rd_pulse_o,
    output logic                  irq_o
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t             state;
    state_t             state_next;
    logic               mapped;
    logic [IW-1:0]      idx;
    logic               start;
    logic [NREGS-1:0]   wr_en;
    logic [NREGS-1:0]   rd_en;
    logic [31:0]        rdat;
    logic [31:0]        reg_q [NREGS];
    logic               ack_next;
    logic               err_next;
    logic [31:0]        dat_next;

    // Any upper address bit set or an index past the last register is unmapped.
    assign mapped = (adr_i < 30'(NREGS));
    assign idx    = adr_i[IW+1:2];
    assign start  = (state == IDLE) && stb_i;

    // One-hot access strobes and read mux for the addressed register.
    always_comb begin
        wr_en = '0;
        rd_en = '0;
        rdat  = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (mapped && (idx == IW'(k))) begin
                wr_en[k] = start && we_i;
                rd_en[k] = start && !we_i;
                rdat     = reg_q[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_cell
            wb_regbank_cell #(
                .MODE        (MODES[g*2 +: 2]),
                .RESET_VALUE (RESET_VALUES[g*32 +: 32])
            ) u_cell (
                .clk    (clk_i),
                .rst    (rst_i),
                .wr_en  (wr_en[g]),
                .sel    (sel_i),
                .wdat   (dat_i),
                .hw_we  (hw_we_i[g]),
                .hw_dat (hw_dat_i[g*32 +: 32]),
                .hw_set (hw_set_i[g*32 +: 32]),
                .q      (reg_q[g])
            );
            assign hw_q_o[g*32 +: 32] = reg_q[g];
        end
    endgenerate

    // Interrupt is raised while any bit of any W1C register is set.
    always_comb begin
        irq_o = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            if (MODES[k*2 +: 2] == MODE_W1C) begin
                irq_o = irq_o | (|reg_q[k]);
            end
        end
    end

    // Handshake: accept in IDLE, respond for exactly one cycle in RESP.
    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        dat_next   = '0;
        case (state)
            IDLE: begin
                if (stb_i) begin
                    state_next = RESP;
                    ack_next   = mapped;
                    err_next   = !mapped;
                    dat_next   = we_i ? 32'h0 : rdat;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered bus response and access strobes, cleared immediately by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            dat_o      <= '0;
            wr_pulse_o <= '0;
            rd_pulse_o <= '0;
        end else begin
            ack_o      <= ack_next;
            err_o      <= err_next;
            dat_o      <= dat_next;
            wr_pulse_o <= wr_en;
            rd_pulse_o <= rd_en;
        end
    end

endmodule
